i2c_cfg_sequencer: RTL and testbench
====================================

I2C_CFG_SEQUENCER -- requirements
Module: i2c_cfg_sequencer

Interface
- REQ-001: The block SHALL have these parameters:
  - LUT_AW, 9: LUT index width.
  - ADDR_W, 8: register address width (8 or 16).
  - TICK_CYC, 50000: clk cycles per delay tick.
  - PWR_WAIT, 1000000: clk cycles to wait after reset before the first entry.
  - MAX_RETRY, 3: re-issues per NACKed entry.
  - SKIP_ON_ERR, 0: 1 = continue after an exhausted entry; 0 = abort.
  - AUTO_START, 1: 1 = start automatically after reset.
- REQ-002: Clock, reset, start and LUT ports:
  - clk  in  1  sole clock; all logic on rising edge.
  - rst_n  in  1  asynchronous, active-low reset.
  - cfg_start  in  1  single-cycle pulse that starts a configuration run.
  - lut_index  out  LUT_AW  entry index presented to the external config LUT.
  - lut_data  in  16+ADDR_W  combinational LUT output, {dev[7:0], addr[ADDR_W-1:0], data[7:0]}.
  - lut_size  in  LUT_AW  number of valid entries.
- REQ-003: I2C master and status ports:
  - i2c_valid  out  1  write request to the I2C master.
  - i2c_ready  in  1  master accepts the request.
  - i2c_dev  out  8  8-bit write slave address.
  - i2c_addr  out  ADDR_W  register address.
  - i2c_wdata  out  8  write data.
  - i2c_done  in  1  single-cycle transaction-complete pulse.
  - i2c_nack  in  1  qualifies i2c_done; high = slave NACK.
  - cfg_busy  out  1  run in progress.
  - cfg_done  out  1  run finished (level).
  - cfg_err  out  1  sticky error flag.
  - err_index  out  LUT_AW  index of the first exhausted entry.

Function
- REQ-004: FSM states SHALL be IDLE, PWAIT, FETCH, ISSUE, WAIT_RSP, DELAY, NEXT, DONE, FAIL.
- REQ-005: Starting a run:
  - IDLE -> PWAIT on cfg_start.
  - IDLE -> PWAIT on the first cycle after reset release when AUTO_START=1.
  - Entry to PWAIT clears lut_index, retry count, cfg_done, cfg_err and err_index.
- REQ-006: PWAIT SHALL count PWR_WAIT cycles, then go to FETCH; if lut_size==0 it goes to DONE instead.
- REQ-007: FETCH SHALL last one cycle and register lut_data into i2c_dev/i2c_addr/i2c_wdata.
  - dev==8'hFF: delay entry, go to DELAY.
  - Otherwise go to ISSUE.
- REQ-008: ISSUE SHALL hold i2c_valid high with stable i2c_dev/i2c_addr/i2c_wdata until the cycle i2c_valid&i2c_ready, then go to WAIT_RSP with i2c_valid low the next cycle.
- REQ-009: In WAIT_RSP, on i2c_done:
  - i2c_nack=0: go to NEXT.
  - i2c_nack=1 and retries<MAX_RETRY: increment retries, go to ISSUE with the same entry.
  - i2c_nack=1 and retries exhausted: capture err_index on the first failure only, set cfg_err, then go to NEXT if SKIP_ON_ERR=1, else FAIL.
- REQ-010: DELAY SHALL wait lut_data[15:0] × TICK_CYC cycles, then go to NEXT.
  - A count of 0 means one cycle.
  - The counter is wide enough for 65535×TICK_CYC without wrap.
- REQ-011: NEXT SHALL clear retries and increment lut_index.
  - If the incremented value == lut_size, go to DONE; otherwise go to FETCH.
  - The comparison is full-width, so lut_size = 2^LUT_AW-1 terminates correctly.
- REQ-012: DONE and FAIL SHALL hold cfg_done=1 and return to PWAIT only on cfg_start. cfg_done is also 1 in FAIL.
- REQ-013: cfg_busy SHALL be 1 in every state except IDLE, DONE and FAIL.
- REQ-014: cfg_start SHALL be ignored while cfg_busy=1.
- REQ-015: i2c_done outside WAIT_RSP SHALL be ignored.
- REQ-016: lut_index SHALL change only in NEXT and PWAIT entry, so the external LUT has at least one full cycle to settle before FETCH samples it.

Reset
- REQ-017: While rst_n=0, asynchronously and regardless of the current state:
  - State is IDLE.
  - lut_index, all counters, i2c_valid, i2c_dev, i2c_addr, i2c_wdata, cfg_busy, cfg_done, cfg_err and err_index are 0.
  - An in-flight I2C request is abandoned without completion.

Verification
- REQ-018: Nominal run: PWR_WAIT=4, lut_size=3, all ACK -> exactly 3 handshakes in index order 0,1,2; cfg_done=1 and cfg_err=0 one cycle after the third NEXT.
- REQ-019: Retry recovers: entry 1 NACKed twice, MAX_RETRY=3 -> entry 1 issued 3 times; cfg_err=0; run completes.
- REQ-020: Retry exhausted: entry 2 always NACKs, MAX_RETRY=1 ->
  - SKIP_ON_ERR=0: 2 issues, FAIL, err_index=2, cfg_err=1, no entry 3 issued.
  - SKIP_ON_ERR=1: remaining entries issued, DONE, cfg_err=1.
- REQ-021: Delay and empty table: entry {8'hFF, 16'd5}, TICK_CYC=10 -> 50 cycles with no i2c_valid. lut_size=0 -> DONE with no handshake.
- REQ-022: Reset and restart: rst_n low while i2c_valid=1 -> all outputs 0 immediately. cfg_start while busy -> ignored. cfg_start in DONE -> new run from index 0 with flags cleared.
- REQ-023: Backpressure: i2c_ready held low 20 cycles -> i2c_valid and payload stable throughout; exactly one transaction counted.

Source files
------------

// File: rtl/i2c_cfg_sequencer.sv
// i2c_cfg_sequencer: walks an external config LUT (lut_*) issuing I2C writes (i2c_*) with delay entries, NACK retries and run status (cfg_*)
module i2c_cfg_sequencer #(
  parameter int LUT_AW      = 9,
  parameter int ADDR_W      = 8,
  parameter int TICK_CYC    = 50000,
  parameter int PWR_WAIT    = 1000000,
  parameter int MAX_RETRY   = 3,
  parameter int SKIP_ON_ERR = 0,
  parameter int AUTO_START  = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_start,
  output logic [LUT_AW-1:0]      lut_index,
  input  logic [16+ADDR_W-1:0]   lut_data,
  input  logic [LUT_AW-1:0]      lut_size,
  output logic                   i2c_valid,
  input  logic                   i2c_ready,
  output logic [7:0]             i2c_dev,
  output logic [ADDR_W-1:0]      i2c_addr,
  output logic [7:0]             i2c_wdata,
  input  logic                   i2c_done,
  input  logic                   i2c_nack,
  output logic                   cfg_busy,
  output logic                   cfg_done,
  output logic                   cfg_err,
  output logic [LUT_AW-1:0]      err_index
);
  localparam int DW = 16 + $clog2(TICK_CYC + 1);
  localparam int PW = $clog2(PWR_WAIT + 1) + 1;
  localparam int CW = DW > PW ? DW : PW;
  localparam int RW = $clog2(MAX_RETRY + 1) + 1;
  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] PWAIT    = 4'd1;
  localparam logic [3:0] FETCH    = 4'd2;
  localparam logic [3:0] ISSUE    = 4'd3;
  localparam logic [3:0] WAIT_RSP = 4'd4;
  localparam logic [3:0] DELAY    = 4'd5;
  localparam logic [3:0] NEXT     = 4'd6;
  localparam logic [3:0] DONE     = 4'd7;
  localparam logic [3:0] FAIL     = 4'd8;
  logic [3:0]        state;
  logic [CW-1:0]     cnt;
  logic [RW-1:0]     retry;
  logic              boot;
  logic [LUT_AW-1:0] nxt_index;
  logic [7:0]        fetch_dev;
  assign fetch_dev = lut_data[ADDR_W+15:ADDR_W+8];
  assign nxt_index = lut_index + 1'b1;
  assign i2c_valid = state == ISSUE;
  assign cfg_done  = state == DONE || state == FAIL;
  assign cfg_busy  = !(state == IDLE || cfg_done);
  // cnt is shared: power-up wait count in PWAIT, delay length in DELAY; both count down to 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      retry     <= '0;
      boot      <= 1'b1;
      lut_index <= '0;
      i2c_dev   <= '0;
      i2c_addr  <= '0;
      i2c_wdata <= '0;
      cfg_err   <= 1'b0;
      err_index <= '0;
    end else begin
      boot <= 1'b0;
      case (state)
        IDLE, DONE, FAIL:
          if (cfg_start || (AUTO_START != 0 && boot)) begin
            state     <= PWAIT;
            cnt       <= CW'(PWR_WAIT);
            retry     <= '0;
            lut_index <= '0;
            cfg_err   <= 1'b0;
            err_index <= '0;
          end
        PWAIT:
          if (cnt <= CW'(1)) state <= lut_size == '0 ? DONE : FETCH;
          else cnt <= cnt - 1'b1;
        FETCH: begin
          i2c_dev   <= fetch_dev;
          i2c_addr  <= lut_data[ADDR_W+7:8];
          i2c_wdata <= lut_data[7:0];
          cnt       <= CW'(lut_data[15:0]) * CW'(TICK_CYC);
          state     <= fetch_dev == 8'hFF ? DELAY : ISSUE;
        end
        ISSUE:
          if (i2c_ready) state <= WAIT_RSP;
        WAIT_RSP:
          if (i2c_done) begin
            if (!i2c_nack) state <= NEXT;
            else if (retry < RW'(MAX_RETRY)) begin
              retry <= retry + 1'b1;
              state <= ISSUE;
            end else begin
              if (!cfg_err) err_index <= lut_index;
              cfg_err <= 1'b1;
              state   <= SKIP_ON_ERR != 0 ? NEXT : FAIL;
            end
          end
        DELAY:
          if (cnt <= CW'(1)) state <= NEXT;
          else cnt <= cnt - 1'b1;
        NEXT: begin
          retry     <= '0;
          lut_index <= nxt_index;
          state     <= nxt_index == lut_size ? DONE : FETCH;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// tb_i2c_cfg_sequencer: scoreboard bench for two sequencer configs (abort-on-error and skip-on-error)
module tb_i2c_cfg_sequencer;
  localparam int AW = 9;
  localparam int TICK = 10;
  typedef struct {logic [7:0] dev; logic [7:0] addr; logic [7:0] data; int gap;} txn_t;
  logic clk, rst_n, cfg_start, sel, slave_en, rdy, sdone, snack, spur;
  logic [AW-1:0] size, a_idx, b_idx, a_eidx, b_eidx;
  logic [23:0] a_lut, b_lut;
  logic a_v, b_v, a_busy, b_busy, a_done, b_done, a_err, b_err;
  logic [7:0] a_dev, a_addr, a_wd, b_dev, b_addr, b_wd;
  logic [7:0] tdev [512];
  logic [7:0] taddr [512];
  logic [7:0] tdata [512];
  int np [512];
  int att [512];
  logic v, busy, done, err, dn, nk;
  logic [7:0] dev, addr, wd;
  logic [AW-1:0] eidx, idx;
  txn_t expq [$];
  bit exp_err;
  int exp_eidx, n_chk, n_pass;
  assign a_lut = {tdev[a_idx], taddr[a_idx], tdata[a_idx]};
  assign b_lut = {tdev[b_idx], taddr[b_idx], tdata[b_idx]};
  assign dn = sdone | spur;
  assign nk = snack | spur;
  assign v = sel ? b_v : a_v;
  assign busy = sel ? b_busy : a_busy;
  assign done = sel ? b_done : a_done;
  assign err = sel ? b_err : a_err;
  assign dev = sel ? b_dev : a_dev;
  assign addr = sel ? b_addr : a_addr;
  assign wd = sel ? b_wd : a_wd;
  assign eidx = sel ? b_eidx : a_eidx;
  assign idx = sel ? b_idx : a_idx;
  i2c_cfg_sequencer #(.LUT_AW(AW), .ADDR_W(8), .TICK_CYC(TICK), .PWR_WAIT(4), .MAX_RETRY(3),
    .SKIP_ON_ERR(0), .AUTO_START(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start & !sel), .lut_index(a_idx), .lut_data(a_lut),
    .lut_size(size), .i2c_valid(a_v), .i2c_ready(rdy & !sel), .i2c_dev(a_dev), .i2c_addr(a_addr),
    .i2c_wdata(a_wd), .i2c_done(dn & !sel), .i2c_nack(nk), .cfg_busy(a_busy), .cfg_done(a_done),
    .cfg_err(a_err), .err_index(a_eidx));
  i2c_cfg_sequencer #(.LUT_AW(AW), .ADDR_W(8), .TICK_CYC(TICK), .PWR_WAIT(4), .MAX_RETRY(1),
    .SKIP_ON_ERR(1), .AUTO_START(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start & sel), .lut_index(b_idx), .lut_data(b_lut),
    .lut_size(size), .i2c_valid(b_v), .i2c_ready(rdy & sel), .i2c_dev(b_dev), .i2c_addr(b_addr),
    .i2c_wdata(b_wd), .i2c_done(dn & sel), .i2c_nack(nk), .cfg_busy(b_busy), .cfg_done(b_done),
    .cfg_err(b_err), .err_index(b_eidx));
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  task automatic gen(input int n);
    for (int i = 0; i < 512; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        tdev[i] = 8'hFF;
        taddr[i] = 8'h00;
        tdata[i] = 8'($urandom_range(0, 3));
      end else begin
        tdev[i] = 8'($urandom_range(1, 254));
        taddr[i] = 8'($urandom);
        tdata[i] = 8'($urandom);
      end
      np[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0;
      att[i] = 0;
    end
    size = AW'(n);
  endtask
  task automatic plain(input int n);
    gen(n);
    for (int i = 0; i < 512; i++) begin
      if (tdev[i] == 8'hFF) tdev[i] = 8'h42;
      np[i] = 0;
    end
  endtask
  // Reference: every non-delay entry is issued (nacks+1) times capped at MAX_RETRY+1;
  // gap = idle cycles between a completion and the next request (NEXT+FETCH per step, plus delay length).
  task automatic build(input int mr, input bit skip);
    int g, len, tries;
    g = -1;
    exp_err = 0;
    exp_eidx = 0;
    expq.delete();
    for (int i = 0; i < int'(size); i++) begin
      if (tdev[i] == 8'hFF) begin
        len = int'({taddr[i], tdata[i]}) * TICK;
        if (len < 1) len = 1;
        if (g >= 0) g += len + 2;
        continue;
      end
      tries = (np[i] > mr) ? mr + 1 : np[i] + 1;
      for (int a = 0; a < tries; a++) begin
        expq.push_back('{tdev[i], taddr[i], tdata[i], g});
        g = 0;
      end
      g = 2;
      if (np[i] > mr) begin
        if (!exp_err) begin
          exp_err = 1;
          exp_eidx = i;
        end
        if (!skip) break;
      end
    end
  endtask
  task automatic run(input bit use_start);
    int cyc, bound;
    build(sel ? 1 : 3, sel);
    bound = 3000 + int'(size) * 120;
    @(negedge clk);
    if (use_start) cfg_start = 1;
    else rst_n = 1;
    @(negedge clk);
    cfg_start = 0;
    spur = 1;
    @(negedge clk);
    spur = 0;
    chk("start_done_clr", done, 0);
    chk("start_err_clr", err, 0);
    chk("start_eidx_clr", eidx, 0);
    chk("start_busy", busy, 1);
    cyc = 0;
    while (!done && cyc < bound) begin
      @(negedge clk);
      cyc++;
      cfg_start = (cyc == 10 && busy);
    end
    cfg_start = 0;
    if (cyc >= bound) begin
      n_chk++;
      $display("FAIL run_timeout: got no cfg_done after %0d cycles expected cfg_done", cyc);
    end
    chk("run_done", done, 1);
    chk("run_busy", busy, 0);
    chk("run_err", err, exp_err);
    chk("run_err_index", eidx, exp_eidx);
    chk("missing_txns", expq.size(), 0);
  endtask
  initial begin
    int g, lat;
    logic [AW-1:0] ix;
    forever begin
      @(posedge clk);
      #1;
      if (slave_en && rst_n && v) begin
        g = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 3);
        repeat (g) begin @(posedge clk); #1; end
        ix = idx;
        rdy = 1;
        @(posedge clk);
        #1;
        rdy = 0;
        lat = $urandom_range(0, 3);
        repeat (lat) begin @(posedge clk); #1; end
        snack = att[ix] < np[ix];
        att[ix]++;
        sdone = 1;
        @(posedge clk);
        #1;
        sdone = 0;
        snack = 0;
      end
    end
  end
  initial begin
    logic pv, phs, armed;
    logic [23:0] pp;
    int gc, cg;
    txn_t e;
    pv = 0; phs = 0; armed = 0; pp = '0; gc = 0; cg = -1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 0; phs = 0; armed = 0;
      end else begin
        if (pv && !phs) chk("hold_stable", {v, dev, addr, wd}, {1'b1, pp});
        if (dn) begin
          armed = 1;
          gc = 0;
        end else if (!v) gc++;
        if (v && !pv) begin
          cg = armed ? gc : -1;
          armed = 0;
        end
        if (v && rdy) begin
          if (expq.size() == 0) begin
            n_chk++;
            $display("FAIL extra_txn: got %h expected no request", {dev, addr, wd});
          end else begin
            e = expq.pop_front();
            chk("txn", {dev, addr, wd}, {e.dev, e.addr, e.data});
            if (e.gap >= 0) chk("gap", cg, e.gap);
          end
        end
        pv = v;
        phs = v && rdy;
        pp = {dev, addr, wd};
      end
    end
  end
  initial begin
    int w;
    n_chk = 0; n_pass = 0;
    sel = 0; rst_n = 0; cfg_start = 0; slave_en = 1; rdy = 0; sdone = 0; snack = 0; spur = 0;
    plain(3);
    repeat (3) @(negedge clk);
    run(0);
    plain(4); np[1] = 2; run(1);
    plain(5); np[2] = 9; run(1);
    plain(3); tdev[1] = 8'hFF; taddr[1] = 8'h00; tdata[1] = 8'd5; run(1);
    plain(0); run(1);
    plain(511); run(1);
    repeat (12) begin gen($urandom_range(1, 24)); run(1); end
    @(negedge clk);
    #2 rst_n = 0;
    sel = 1;
    plain(5); np[2] = 9; run(0);
    gen(8); np[1] = 4; np[5] = 4; tdev[1] = 8'h11; tdev[5] = 8'h55; run(1);
    repeat (8) begin gen($urandom_range(1, 24)); run(1); end
    slave_en = 0;
    plain(3);
    expq.delete();
    @(negedge clk); cfg_start = 1;
    @(negedge clk); cfg_start = 0;
    w = 0;
    while (!v && w < 50) begin @(negedge clk); w++; end
    chk("valid_before_reset", v, 1);
    #2 rst_n = 0;
    #1 chk("reset_clear", {v, dev, addr, wd, busy, done, err, eidx, idx}, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
